// File: rtl/mrd_rdx_wr_back.sv
// Write-back steering for the mixed-radix DFT memory: 5-lane butterfly beats -> 7 RAM banks.
// Optional bank-collision detection is built when MRD_WR_CONFLICT_CHK_EN is defined.
module mrd_rdx_wr_back #(
    parameter int unsigned W_ADDR = 10,
    parameter int unsigned W_DATA = 18
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stage_start,
    input  logic [2:0]                   cnt_stage,
    input  logic [2:0]                   stage_of_rdx2,
    input  logic [5:0][11:0]             dftpts_div_Nf,
    input  logic                         in_valid,
    input  logic [2:0]                   in_factor,
    input  logic [4:0][2:0]              in_bank_index,
    input  logic [4:0][W_ADDR-1:0]       in_bank_addr,
    input  logic [4:0][W_DATA-1:0]       in_d_real,
    input  logic [4:0][W_DATA-1:0]       in_d_imag,
    output logic [6:0]                   wren,
    output logic [6:0][W_ADDR-1:0]       wraddr,
    output logic [6:0][W_DATA-1:0]       wrdata_real,
    output logic [6:0][W_DATA-1:0]       wrdata_imag,
    output logic                         busy,
    output logic                         wr_end,
    output logic                         err_conflict
);

    typedef enum logic [1:0] {StIdle, StWr, StFlush} state_e;

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] stop_q, stop_d;
    logic        rdx2_q, rdx2_d;
    logic        flush_q, flush_d;

    logic [11:0] stop_sel;
    logic [11:0] stop_new;
    logic        is_rdx2;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stop_d   = stop_q;
        rdx2_d   = rdx2_q;
        flush_d  = flush_q;
        stop_sel = (cnt_stage <= 3'd5) ? dftpts_div_Nf[cnt_stage] : 12'd0;
        is_rdx2  = (cnt_stage == stage_of_rdx2);
        stop_new = is_rdx2 ? (stop_sel >> 1) : stop_sel;
        if (stage_start) begin
            // Also restarts an active stage; the aborted stage never reaches wr_end.
            stop_d  = stop_new;
            rdx2_d  = is_rdx2;
            cnt_d   = 12'd0;
            flush_d = 1'b0;
            state_d = (stop_new == 12'd0) ? StFlush : StWr;
        end else begin
            unique case (state_q)
                StIdle: ;
                StWr: begin
                    if (in_valid) begin
                        cnt_d = cnt_q + 12'd1;
                        if (cnt_q + 12'd1 == stop_q) begin
                            state_d = StFlush;
                            flush_d = 1'b0;
                        end
                    end
                end
                StFlush: begin
                    flush_d = 1'b1;
                    if (flush_q) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 12'd0;
            stop_q  <= 12'd0;
            rdx2_q  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            rdx2_q  <= rdx2_d;
            flush_q <= flush_d;
        end
    end

    assign busy   = (state_q == StWr);
    // The second FLUSH cycle coincides with the last beat's stage-2 output.
    assign wr_end = (state_q == StFlush) && flush_q;

    // Stage 1: register the beat with its per-lane active flags.
    logic [4:0]             act_d, s1_act_q;
    logic [4:0][2:0]        s1_bank_q;
    logic [4:0][W_ADDR-1:0] s1_addr_q;
    logic [4:0][W_DATA-1:0] s1_re_q, s1_im_q;

    always_comb begin
        act_d = '0;
        for (int k = 0; k < 5; k++) begin
            act_d[k] = in_valid && (state_q == StWr) && (in_bank_index[k] != 3'd7) &&
                       (rdx2_q ? (k < 4) : (3'(k) < in_factor));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_act_q  <= '0;
            s1_bank_q <= '0;
            s1_addr_q <= '0;
            s1_re_q   <= '0;
            s1_im_q   <= '0;
        end else begin
            s1_act_q  <= act_d;
            s1_bank_q <= in_bank_index;
            s1_addr_q <= in_bank_addr;
            s1_re_q   <= in_d_real;
            s1_im_q   <= in_d_imag;
        end
    end

    // Stage 2: per-bank decode; descending scan leaves the lowest matching lane in place.
    logic [6:0]             wren_d;
    logic [6:0][W_ADDR-1:0] wraddr_d;
    logic [6:0][W_DATA-1:0] wrre_d, wrim_d;

    always_comb begin
        wren_d   = '0;
        wraddr_d = '0;
        wrre_d   = '0;
        wrim_d   = '0;
        for (int b = 0; b < 7; b++) begin
            for (int k = 4; k >= 0; k--) begin
                if (s1_act_q[k] && (s1_bank_q[k] == 3'(b))) begin
                    wren_d[b]   = 1'b1;
                    wraddr_d[b] = s1_addr_q[k];
                    wrre_d[b]   = s1_re_q[k];
                    wrim_d[b]   = s1_im_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wren        <= '0;
            wraddr      <= '0;
            wrdata_real <= '0;
            wrdata_imag <= '0;
        end else begin
            wren        <= wren_d;
            wraddr      <= wraddr_d;
            wrdata_real <= wrre_d;
            wrdata_imag <= wrim_d;
        end
    end

`ifdef MRD_WR_CONFLICT_CHK_EN
    logic conflict;
    logic err_q;

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 5; j++) begin
                if (s1_act_q[i] && s1_act_q[j] && (s1_bank_q[i] == s1_bank_q[j])) conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stage_start) err_q <= 1'b0;
        else if (conflict)      err_q <= 1'b1;
    end

    assign err_conflict = err_q;
`else
    assign err_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_mrd_rdx_wr_back.sv
// Scoreboard bench for mrd_rdx_wr_back: directed beats, expected bank writes queued per beat.
module tb_mrd_rdx_wr_back;

`ifdef MRD_WR_CONFLICT_CHK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              stage_start;
    logic [2:0]        cnt_stage;
    logic [2:0]        stage_of_rdx2;
    logic [5:0][11:0]  dftpts_div_Nf;
    logic              in_valid;
    logic [2:0]        in_factor;
    logic [4:0][2:0]   in_bank_index;
    logic [4:0][9:0]   in_bank_addr;
    logic [4:0][17:0]  in_d_real;
    logic [4:0][17:0]  in_d_imag;
    logic [6:0]        wren;
    logic [6:0][9:0]   wraddr;
    logic [6:0][17:0]  wrdata_real;
    logic [6:0][17:0]  wrdata_imag;
    logic              busy;
    logic              wr_end;
    logic              err_conflict;

    mrd_rdx_wr_back #(.W_ADDR(10), .W_DATA(18)) dut (
        .clk           (clk),
        .rst           (rst),
        .stage_start   (stage_start),
        .cnt_stage     (cnt_stage),
        .stage_of_rdx2 (stage_of_rdx2),
        .dftpts_div_Nf (dftpts_div_Nf),
        .in_valid      (in_valid),
        .in_factor     (in_factor),
        .in_bank_index (in_bank_index),
        .in_bank_addr  (in_bank_addr),
        .in_d_real     (in_d_real),
        .in_d_imag     (in_d_imag),
        .wren          (wren),
        .wraddr        (wraddr),
        .wrdata_real   (wrdata_real),
        .wrdata_imag   (wrdata_imag),
        .busy          (busy),
        .wr_end        (wr_end),
        .err_conflict  (err_conflict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [6:0]       wren;
        logic [6:0][9:0]  addr;
        logic [6:0][17:0] re;
        logic [6:0][17:0] im;
        logic             wr_end;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every cycle with a write or wr_end must match the next queued expectation.
    always @(negedge clk) begin
        if (wren != 7'd0 || wr_end) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc=%0d got wren=%b wr_end=%b required none",
                         cyc, wren, wr_end);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc != e.cyc || wren != e.wren || wraddr != e.addr || wrdata_real != e.re ||
                    wrdata_imag != e.im || wr_end != e.wr_end || err_conflict != e.err) begin
                    errors++;
                    $display("FAIL write_beat got cyc=%0d wren=%b addr=%h re=%h im=%h end=%b err=%b required cyc=%0d wren=%b addr=%h re=%h im=%h end=%b err=%b",
                             cyc, wren, wraddr, wrdata_real, wrdata_imag, wr_end, err_conflict,
                             e.cyc, e.wren, e.addr, e.re, e.im, e.wr_end, e.err);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    function automatic logic [17:0] dre(input int j, input int k);
        return 18'(100 * j + k);
    endfunction

    function automatic logic [17:0] dim(input int j, input int k);
        return 18'(100 * j + k + 50);
    endfunction

    function automatic exp_t blank(input int c, input logic e_end, input logic err);
        exp_t e;
        e.cyc = c; e.wren = '0; e.addr = '0; e.re = '0; e.im = '0;
        e.wr_end = e_end; e.err = err;
        return e;
    endfunction

    // Expect bank b to receive lane k of beat j at address a.
    function automatic exp_t put(input exp_t ei, input int b, input int j, input int k,
                                 input logic [9:0] a);
        exp_t e;
        e = ei;
        e.wren[b] = 1'b1; e.addr[b] = a; e.re[b] = dre(j, k); e.im[b] = dim(j, k);
        return e;
    endfunction

    task automatic start_stage(input logic [2:0] cs);
        cnt_stage   = cs;
        stage_start = 1'b1;
        step();
        stage_start = 1'b0;
    endtask

    task automatic beat(input int j, input logic [2:0] f, input logic [4:0][2:0] bk,
                        input logic [4:0][9:0] ad);
        in_valid      = 1'b1;
        in_factor     = f;
        in_bank_index = bk;
        in_bank_addr  = ad;
        for (int k = 0; k < 5; k++) begin
            in_d_real[k] = dre(j, k);
            in_d_imag[k] = dim(j, k);
        end
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [4:0][2:0] bk;
        logic [4:0][9:0] ad;
        exp_t            e;
        int              c;

        rst = 1'b1; stage_start = 1'b0; cnt_stage = '0; stage_of_rdx2 = 3'd2;
        dftpts_div_Nf = '0; in_valid = 1'b0; in_factor = '0; in_bank_index = '0;
        in_bank_addr = '0; in_d_real = '0; in_d_imag = '0;
        repeat (3) step();
        check("reset_wren", 32'(wren), 32'd0);
        check("reset_wraddr_or", 32'(|wraddr), 32'd0);
        check("reset_wrdata_or", 32'(|{wrdata_real, wrdata_imag}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_end", 32'(wr_end), 32'd0);
        check("reset_err", 32'(err_conflict), 32'd0);
        rst = 1'b0;
        step();

        // Radix-5 stage, 4 beats, lane k -> bank k at k+10*beat.
        dftpts_div_Nf[0] = 12'd4;
        start_stage(3'd0);
        check("r5_busy", 32'(busy), 32'd1);
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 5; k++) begin bk[k] = 3'(k); ad[k] = 10'(k + 10 * j); end
            c = cyc;
            e = blank(c + 2, j == 3, 1'b0);
            for (int b = 0; b < 5; b++) e = put(e, b, j, b, 10'(b + 10 * j));
            exp_q.push_back(e);
            beat(j, 3'd5, bk, ad);
        end
        repeat (4) step();
        check("r5_busy_done", 32'(busy), 32'd0);

        // RDX2 stage: stop = 6>>1 = 3; lane 4 (bank 6) masked off.
        dftpts_div_Nf[2] = 12'd6;
        start_stage(3'd2);
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 4; k++) begin bk[k] = 3'(k); ad[k] = 10'(20 + k + 10 * j); end
            bk[4] = 3'd6; ad[4] = 10'd99;
            c = cyc;
            e = blank(c + 2, j == 2, 1'b0);
            for (int b = 0; b < 4; b++) e = put(e, b, j, b, 10'(20 + b + 10 * j));
            exp_q.push_back(e);
            beat(j, 3'd2, bk, ad);
        end
        repeat (4) step();

        // Nf=3: banks {5,6,0,7,7} then {1,2,3,4,5} with lanes 3,4 beyond Nf.
        dftpts_div_Nf[1] = 12'd2;
        start_stage(3'd1);
        for (int k = 0; k < 5; k++) ad[k] = 10'(40 + k);
        bk[0] = 3'd5; bk[1] = 3'd6; bk[2] = 3'd0; bk[3] = 3'd7; bk[4] = 3'd7;
        c = cyc;
        e = blank(c + 2, 1'b0, 1'b0);
        e = put(e, 5, 0, 0, 10'd40);
        e = put(e, 6, 0, 1, 10'd41);
        e = put(e, 0, 0, 2, 10'd42);
        exp_q.push_back(e);
        beat(0, 3'd3, bk, ad);
        for (int k = 0; k < 5; k++) bk[k] = 3'(k + 1);
        c = cyc;
        e = blank(c + 2, 1'b1, 1'b0);
        e = put(e, 1, 1, 0, 10'd40);
        e = put(e, 2, 1, 1, 10'd41);
        e = put(e, 3, 1, 2, 10'd42);
        exp_q.push_back(e);
        beat(1, 3'd3, bk, ad);
        repeat (4) step();

        // Zero-beat stage: wr_end alone, two cycles after stage_start.
        dftpts_div_Nf[3] = 12'd0;
        c = cyc;
        exp_q.push_back(blank(c + 2, 1'b1, 1'b0));
        start_stage(3'd3);
        check("stop0_busy", 32'(busy), 32'd0);
        repeat (4) step();

        // Beat in IDLE is dropped.
        for (int k = 0; k < 5; k++) begin bk[k] = 3'(k); ad[k] = 10'(k); end
        beat(0, 3'd5, bk, ad);
        repeat (4) step();
        check("idle_busy", 32'(busy), 32'd0);

        // Abort: reset after 2 of 4 beats; beat 1 never reaches the banks.
        start_stage(3'd0);
        c = cyc;
        e = blank(c + 2, 1'b0, 1'b0);
        for (int b = 0; b < 5; b++) e = put(e, b, 0, b, 10'(b));
        exp_q.push_back(e);
        beat(0, 3'd5, bk, ad);
        beat(1, 3'd5, bk, ad);
        rst = 1'b1;
        step();
        check("abort_wren", 32'(wren), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wr_end", 32'(wr_end), 32'd0);
        rst = 1'b0;
        repeat (4) step();
        dftpts_div_Nf[1] = 12'd1;
        start_stage(3'd1);
        c = cyc;
        e = blank(c + 2, 1'b1, 1'b0);
        for (int b = 0; b < 5; b++) e = put(e, b, 2, b, 10'(b));
        exp_q.push_back(e);
        beat(2, 3'd5, bk, ad);
        repeat (4) step();

        // Lanes 0 and 2 both target bank 4: lane 0 wins; collision flag when built.
        dftpts_div_Nf[4] = 12'd1;
        start_stage(3'd4);
        bk[0] = 3'd4; bk[1] = 3'd0; bk[2] = 3'd4; bk[3] = 3'd1; bk[4] = 3'd2;
        for (int k = 0; k < 5; k++) ad[k] = 10'(7 + k);
        c = cyc;
        e = blank(c + 2, 1'b1, ChkEn);
        e = put(e, 4, 3, 0, 10'd7);
        e = put(e, 0, 3, 1, 10'd8);
        e = put(e, 1, 3, 3, 10'd10);
        e = put(e, 2, 3, 4, 10'd11);
        exp_q.push_back(e);
        beat(3, 3'd5, bk, ad);
        repeat (5) step();
        check("conflict_held", 32'(err_conflict), 32'(ChkEn));
        dftpts_div_Nf[5] = 12'd0;
        c = cyc;
        exp_q.push_back(blank(c + 2, 1'b1, 1'b0));
        start_stage(3'd5);
        repeat (3) step();
        check("conflict_cleared", 32'(err_conflict), 32'd0);

        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mrd_rdx_wr_back.md
Name: mrd_rdx_wr_back

Overview:
- Write-back side of the mixed-radix DFT memory.
- Takes one 5-lane butterfly result beat per cycle from the radix-2/3/4/5 engine. Each beat carries the bank_index/bank_addr that the read side attached to it.
- Steers each active lane into one of 7 RAM banks at the carried address. Counts the beats of the current stage and pulses wr_end when the stage's write-back is complete.
- Sits between the rdx2345 butterfly output and the 7-bank RAM write ports. It is the counterpart of the stage read sequencer.

Parameters:
- W_ADDR, 10, bank address width (ceil(log2(4096/7))).
- W_DATA, 18, real/imag sample width.

Ports:
- clk  in  1  the block's only clock
- rst  in  1  reset; synchronous, active-high
- stage_start  in  1  one-cycle pulse; arms write-back for cnt_stage
- cnt_stage  in  3  current stage index, 0..5
- stage_of_rdx2  in  3  index of the stage executed as two radix-2 butterflies
- dftpts_div_Nf  in  6x12  beats per stage, indexed by cnt_stage
- in_valid  in  1  butterfly result beat valid
- in_factor  in  3  radix of this beat (Nf)
- in_bank_index  in  5x3  target bank per lane; 7 = lane unused
- in_bank_addr  in  5xW_ADDR  target address per lane
- in_d_real, in_d_imag  in  5xW_DATA each  lane data
- wren  out  7  per-bank write enable
- wraddr  out  7xW_ADDR  per-bank write address
- wrdata_real, wrdata_imag  out  7xW_DATA each  per-bank write data
- busy  out  1  high in state WR
- wr_end  out  1  one-cycle pulse, same cycle as the final wren of the stage
- err_conflict  out  1  sticky bank-collision flag (optional feature)

Behaviour:
- Reset: state IDLE; beat counter 0; wren, wraddr, wrdata_*, busy, wr_end and err_conflict all 0.
- Reset mid-operation aborts the stage with no wr_end. In-flight pipeline beats are discarded: wren=0 on the cycle after rst is sampled.

State machine, states IDLE, WR, FLUSH:
- IDLE -> WR on stage_start.
  - Latch stop = dftpts_div_Nf[cnt_stage], or that value >>1 when cnt_stage==stage_of_rdx2.
  - Latch the lane mask. RDX2 stage: lanes 0-3 enabled. Otherwise: lane k enabled iff k < dftpts stage Nf, i.e. k < in_factor of each beat.
  - Clear the counter.
- WR: each in_valid beat is accepted and increments the counter. The beat that makes counter==stop moves the FSM to FLUSH.
- FLUSH: lasts 2 cycles, which drains the pipeline. wr_end pulses in the cycle the last beat's wren is driven. FSM then returns to IDLE.
- stop==0: WR -> FLUSH immediately. wr_end pulses 2 cycles after stage_start with no wren.
- stage_start while in WR/FLUSH: restart. Re-latch stop and mask, counter=0, no wr_end for the aborted stage. Beats already in the pipeline are still written.
- in_valid in IDLE: beat is dropped, no write, counter unchanged.
- Beats beyond stop never occur inside WR, because the FSM has already left WR. Any such beat is dropped.

Datapath, 2-cycle latency, in_valid at cycle t -> wren at t+2:
- Stage 1 registers the beat. A lane is active iff in_valid, the lane is enabled by the mask, and bank_index != 7.
- Stage 2 decodes per bank b:
  - wren[b] = OR over active lanes with bank_index==b.
  - wraddr[b] / wrdata[b] come from the lowest-numbered matching lane (fixed priority 0..4).
  - When wren[b]=0, wraddr[b]=0 and wrdata[b]=0.
- No arithmetic on data; addresses are passed through unmodified.
- busy = (state==WR).

Optional Feature:
- MRD_WR_CONFLICT_CHK_EN defined:
  - In stage 1, if two active lanes of one beat share a bank_index, err_conflict sets one cycle later (with that beat's stage-2 cycle).
  - err_conflict stays high until rst or the next stage_start.
  - The priority write still happens.
- Not defined: err_conflict tied 0; no compare logic is built.

Test Plan:
- Radix-5 stage: cnt_stage=0, Nf=5, dftpts_div_Nf[0]=4, stage_start, then 4 beats with bank_index {0,1,2,3,4}, addr k+10*beat -> wren=7'b0011111 on cycles t+2..t+5; wraddr[3]=3,13,23,33; wr_end high with the 4th wren only.
- RDX2 stage: stage_of_rdx2=2, cnt_stage=2, dftpts_div_Nf[2]=6 -> stop=3. Beat with lane 4 bank 6 -> wren[6] never set; wr_end after 3rd beat.
- Unused lane: Nf=3, bank_index {5,6,0,7,7} -> wren=7'b1100001 (banks 0,5,6); wraddr of banks 1-4 =0.
- Boundary: dftpts_div_Nf=0 -> no wren, wr_end exactly 2 cycles after stage_start. in_valid in IDLE -> no wren.
- Abort: assert rst after 2 of 4 beats -> next cycle all wren=0, busy=0, no wr_end. New stage_start then works normally.
- With MRD_WR_CONFLICT_CHK_EN: lanes 0 and 2 both bank 4, addrs 7 and 9 -> wren[4]=1, wraddr[4]=7, err_conflict=1 and held until the next stage_start.
